// File: rtl/mips_hazard_pkg.sv
// Shared definitions for the pipeline hazard detection logic.
package mips_hazard_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned PERF_W = 16;

    typedef enum logic {
        HDU_IDLE = 1'b0,
        HDU_HOLD = 1'b1
    } hdu_state_e;

    localparam logic [REG_W-1:0]  REG_ZERO      = 5'd0;
    localparam logic [PERF_W-1:0] STALL_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/hdu_hazard_compare.sv
// Combinational producer/consumer register match: flags when a pending load
// writes a register that the ID instruction reads. Register 0 never matches.
module hdu_hazard_compare
    import mips_hazard_pkg::*;
(
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    input  logic [4:0] exe_rt_i,
    input  logic       exe_mem_read_i,
    output logic       hit_o
);

    logic rs_match;
    logic rt_match;

    // Source-operand match against the load destination
    always_comb begin
        rs_match = (exe_rt_i == id_rs_i);
        rt_match = id_uses_rt_i && (exe_rt_i == id_rt_i);
        hit_o    = exe_mem_read_i && (exe_rt_i != REG_ZERO) && (rs_match || rt_match);
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use hazard detection: stalls PC and IF/ID and bubbles ID/EXE for
// LOAD_STALLS cycles per hazard; generates the IF/ID flush for branches taken
// in ID. Optional stall-cycle counter enabled by macro HDU_PERF_COUNT_EN.
module hazard_detection_unit
    import mips_hazard_pkg::*;
#(
    parameter int unsigned LOAD_STALLS = 1,
    parameter int unsigned CNT_W       = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  I_HDU_ID_RS,
    input  logic [4:0]  I_HDU_ID_RT,
    input  logic        I_HDU_ID_UsesRT,
    input  logic [4:0]  I_HDU_EXE_RT,
    input  logic        I_HDU_EXE_MemRead,
    input  logic        I_HDU_BranchTaken,
    input  logic        I_HDU_ExtStall,
    output logic        O_HDU_PCWrite,
    output logic        O_HDU_IFID_Write,
    output logic        O_HDU_IDEXE_Bubble,
    output logic        O_HDU_IFID_Flush,
    output logic        O_HDU_Stalling,
    output logic [15:0] O_HDU_StallCycles
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_STALLS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    hdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             hit_c;
    logic             stall_c;

    hdu_hazard_compare u_cmp (
        .id_rs_i        (I_HDU_ID_RS),
        .id_rt_i        (I_HDU_ID_RT),
        .id_uses_rt_i   (I_HDU_ID_UsesRT),
        .exe_rt_i       (I_HDU_EXE_RT),
        .exe_mem_read_i (I_HDU_EXE_MemRead),
        .hit_o          (hit_c)
    );

    // Stall is Mealy on a fresh hit in IDLE, and unconditional while holding
    assign stall_c = ((state_q == HDU_IDLE) && hit_c) || (state_q == HDU_HOLD);

    // Stall FSM; frozen while the external stall is asserted
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= HDU_IDLE;
            cnt_q   <= '0;
        end else if (!I_HDU_ExtStall) begin
            case (state_q)
                HDU_IDLE: begin
                    if (hit_c && (LOAD_STALLS > 1)) begin
                        state_q <= HDU_HOLD;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                HDU_HOLD: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= HDU_IDLE;
                    end
                end
                default: begin
                    state_q <= HDU_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign O_HDU_Stalling = (state_q == HDU_HOLD);

    // Pipeline enables: reset forces free-run, external freeze beats hazard stall
    always_comb begin
        O_HDU_PCWrite      = 1'b1;
        O_HDU_IFID_Write   = 1'b1;
        O_HDU_IDEXE_Bubble = 1'b0;
        O_HDU_IFID_Flush   = 1'b0;
        if (RESET) begin
            O_HDU_PCWrite = 1'b1;
        end else if (I_HDU_ExtStall) begin
            O_HDU_PCWrite    = 1'b0;
            O_HDU_IFID_Write = 1'b0;
        end else if (stall_c) begin
            O_HDU_PCWrite      = 1'b0;
            O_HDU_IFID_Write   = 1'b0;
            O_HDU_IDEXE_Bubble = 1'b1;
        end else begin
            O_HDU_IFID_Flush = I_HDU_BranchTaken;
        end
    end

`ifdef HDU_PERF_COUNT_EN
    logic [15:0] perf_q;

    // Saturating count of hazard stall cycles not masked by the external freeze
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            perf_q <= '0;
        end else if (stall_c && !I_HDU_ExtStall && (perf_q != STALL_CNT_MAX)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign O_HDU_StallCycles = perf_q;
`else
    assign O_HDU_StallCycles = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Bench for hazard_detection_unit: three instances (LOAD_STALLS 1, 2, 3) share
// the same stimulus; a reference model pushes expected outputs per cycle.
module tb_hazard_detection_unit;

    typedef struct packed {
        logic        pcw;
        logic        ifidw;
        logic        bub;
        logic        flush;
        logic        stalling;
        logic [15:0] perf;
    } obs_t;

`ifdef HDU_PERF_COUNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [4:0] id_rs, id_rt, exe_rt;
    logic       uses_rt, mem_read, br_taken, ext_stall;

    logic        pcw   [3];
    logic        ifidw [3];
    logic        bub   [3];
    logic        flush [3];
    logic        stl   [3];
    logic [15:0] scyc  [3];

    int          checks = 0;
    int          errors = 0;
    obs_t        sb_q[$];
    int          m_rem  [3];
    logic [15:0] m_perf [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hazard_detection_unit #(.LOAD_STALLS(1), .CNT_W(3)) u_ls1 (
        .CLK(clk), .RESET(rst), .I_HDU_ID_RS(id_rs), .I_HDU_ID_RT(id_rt),
        .I_HDU_ID_UsesRT(uses_rt), .I_HDU_EXE_RT(exe_rt), .I_HDU_EXE_MemRead(mem_read),
        .I_HDU_BranchTaken(br_taken), .I_HDU_ExtStall(ext_stall),
        .O_HDU_PCWrite(pcw[0]), .O_HDU_IFID_Write(ifidw[0]), .O_HDU_IDEXE_Bubble(bub[0]),
        .O_HDU_IFID_Flush(flush[0]), .O_HDU_Stalling(stl[0]), .O_HDU_StallCycles(scyc[0])
    );

    hazard_detection_unit #(.LOAD_STALLS(2), .CNT_W(3)) u_ls2 (
        .CLK(clk), .RESET(rst), .I_HDU_ID_RS(id_rs), .I_HDU_ID_RT(id_rt),
        .I_HDU_ID_UsesRT(uses_rt), .I_HDU_EXE_RT(exe_rt), .I_HDU_EXE_MemRead(mem_read),
        .I_HDU_BranchTaken(br_taken), .I_HDU_ExtStall(ext_stall),
        .O_HDU_PCWrite(pcw[1]), .O_HDU_IFID_Write(ifidw[1]), .O_HDU_IDEXE_Bubble(bub[1]),
        .O_HDU_IFID_Flush(flush[1]), .O_HDU_Stalling(stl[1]), .O_HDU_StallCycles(scyc[1])
    );

    hazard_detection_unit #(.LOAD_STALLS(3), .CNT_W(3)) u_ls3 (
        .CLK(clk), .RESET(rst), .I_HDU_ID_RS(id_rs), .I_HDU_ID_RT(id_rt),
        .I_HDU_ID_UsesRT(uses_rt), .I_HDU_EXE_RT(exe_rt), .I_HDU_EXE_MemRead(mem_read),
        .I_HDU_BranchTaken(br_taken), .I_HDU_ExtStall(ext_stall),
        .O_HDU_PCWrite(pcw[2]), .O_HDU_IFID_Write(ifidw[2]), .O_HDU_IDEXE_Bubble(bub[2]),
        .O_HDU_IFID_Flush(flush[2]), .O_HDU_Stalling(stl[2]), .O_HDU_StallCycles(scyc[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference load-use hit: load in EXE writing a non-zero reg read in ID
    function automatic logic ref_hit(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic u, input logic [4:0] ert, input logic m);
        if (!m || ert == 5'd0) return 1'b0;
        return (rs == ert) || (u && rt == ert);
    endfunction

    // Compute expected outputs for this cycle and advance the model
    function automatic obs_t model_cycle(input int i, input logic r, input logic h,
                                         input logic b, input logic e);
        obs_t ex;
        logic stall;
        ex = '0;
        if (r) begin
            m_rem[i]  = 0;
            m_perf[i] = 16'h0;
            ex.pcw    = 1'b1;
            ex.ifidw  = 1'b1;
            return ex;
        end
        stall       = (m_rem[i] > 0) || h;
        ex.stalling = (m_rem[i] > 0);
        ex.perf     = PERF ? m_perf[i] : 16'h0;
        if (e) return ex;
        if (stall) begin
            ex.bub = 1'b1;
            if (m_perf[i] != 16'hFFFF) m_perf[i] = m_perf[i] + 16'd1;
        end else begin
            ex.pcw   = 1'b1;
            ex.ifidw = 1'b1;
            ex.flush = b;
        end
        if (m_rem[i] > 0) m_rem[i] = m_rem[i] - 1;
        else if (h) m_rem[i] = i;   // instance i has LOAD_STALLS = i+1
        return ex;
    endfunction

    // One pipeline cycle: drive, push expectations, sample mid-cycle, pop and compare
    task automatic step(input string tag, input logic r, input logic [4:0] rs,
                        input logic [4:0] rt, input logic u, input logic [4:0] ert,
                        input logic m, input logic b, input logic e);
        logic h;
        obs_t o;
        obs_t ex;
        @(posedge clk);
        #1;
        rst = r; id_rs = rs; id_rt = rt; uses_rt = u; exe_rt = ert;
        mem_read = m; br_taken = b; ext_stall = e;
        h = ref_hit(rs, rt, u, ert, m);
        for (int i = 0; i < 3; i++) sb_q.push_back(model_cycle(i, r, h, b, e));
        #5;
        for (int i = 0; i < 3; i++) begin
            o.pcw = pcw[i]; o.ifidw = ifidw[i]; o.bub = bub[i];
            o.flush = flush[i]; o.stalling = stl[i]; o.perf = scyc[i];
            ex = sb_q.pop_front();
            check_eq($sformatf("%s/ls%0d", tag, i + 1), 32'(o), 32'(ex));
        end
    endtask

    task automatic idle(input string tag, input int n);
        for (int k = 0; k < n; k++) step(tag, 1'b0, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; id_rs = '0; id_rt = '0; uses_rt = 1'b0; exe_rt = '0;
        mem_read = 1'b0; br_taken = 1'b0; ext_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin m_rem[i] = 0; m_perf[i] = 16'h0; end

        step("reset", 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        step("reset", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        idle("idle", 1);

        // lw $5 in EXE, add rs=$5 in ID; load then moves on
        step("lu_rs", 1'b0, 5'd5, 5'd9, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        idle("lu_rs_drain", 4);

        // $0 never hazards; rt ignored without UsesRT; rt hazard with UsesRT
        step("zero", 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        step("rt_unused", 1'b0, 5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        step("rt_used", 1'b0, 5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        idle("rt_drain", 4);

        // Branch taken alongside hazard: flush waits for stall to clear
        step("br_hit", 1'b0, 5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++)
            step("br_wait", 1'b0, 5'd6, 5'd0, 1'b0, 5'd6, 1'b0, 1'b1, 1'b0);
        idle("br_drain", 2);

        // External freeze mid-hold, then reset mid-hold
        step("ext_hit", 1'b0, 5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        idle("ext_hold", 1);
        step("ext_on", 1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1);
        step("ext_on", 1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1);
        step("rst_hold", 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
        idle("post_rst", 2);

        // Hit arriving under freeze is evaluated once freeze drops
        step("ext_hit_in", 1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1);
        step("ext_hit_out", 1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        idle("ext_drain", 4);

        // Back-to-back loads: hits during hold are ignored
        step("b2b", 1'b0, 5'd10, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
        step("b2b", 1'b0, 5'd11, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
        step("b2b", 1'b0, 5'd12, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0);
        step("b2b", 1'b0, 5'd13, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0);
        idle("b2b_drain", 4);

        // Random mix over a small register range to exercise collisions
        for (int k = 0; k < 80; k++) begin
            step("rand", ($urandom_range(0, 39) == 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) == 0));
        end
        idle("rand_drain", 4);

`ifdef HDU_PERF_COUNT_EN
        step("perf_rst", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step("perf_hit", 1'b0, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
            idle("perf_gap", 2);
        end
        check_eq("perf_ten", 32'(scyc[1]), 32'd10);

        @(posedge clk);
        #1;
        force u_ls2.perf_q = 16'hFFFE;
        #1;
        release u_ls2.perf_q;
        m_perf[1] = 16'hFFFE;
        for (int k = 0; k < 3; k++) begin
            step("perf_sat_hit", 1'b0, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
            idle("perf_sat_gap", 2);
        end
        check_eq("perf_sat", 32'(scyc[1]), 32'h0000FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
- Stall-side complement of the pipeline forwarding unit. It detects load-use hazards that forwarding cannot resolve and resolves them by freezing the PC and the IF/ID register and injecting bubbles into ID/EXE.
- It also generates the IF/ID flush for branches taken in ID.
- Sits between the ID-stage decode and the pipeline register write enables.

Parameters:
- LOAD_STALLS, 1: bubble cycles per load-use hazard; legal range 1..7 (>1 for slow data memory).
- CNT_W, 3: width of the internal stall counter; must satisfy 2^CNT_W > LOAD_STALLS.

Ports:
- CLK  in  1  pipeline clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- I_HDU_ID_RS  in  5  rs of instruction in ID
- I_HDU_ID_RT  in  5  rt of instruction in ID
- I_HDU_ID_UsesRT  in  1  ID instruction reads rt as a source
- I_HDU_EXE_RT  in  5  destination of load in EXE
- I_HDU_EXE_MemRead  in  1  EXE instruction is a load
- I_HDU_BranchTaken  in  1  branch resolved taken in ID
- I_HDU_ExtStall  in  1  external freeze (debug step / halt)
- O_HDU_PCWrite  out  1  PC write enable
- O_HDU_IFID_Write  out  1  IF/ID write enable
- O_HDU_IDEXE_Bubble  out  1  zero ID/EXE control fields this cycle
- O_HDU_IFID_Flush  out  1  clear IF/ID this cycle
- O_HDU_Stalling  out  1  hazard stall active, registered state view
- O_HDU_StallCycles  out  16  stall-cycle count (see Optional Feature)

Behaviour:
- Hazard term, combinational: hit = EXE_MemRead && EXE_RT!=0 && (EXE_RT==ID_RS || (ID_UsesRT && EXE_RT==ID_RT)).
- FSM states: IDLE, HOLD. Counter cnt is CNT_W bits wide.
- IDLE with hit:
  - Stall is asserted in the same cycle (Mealy).
  - If LOAD_STALLS==1, remain in IDLE.
  - Otherwise go to HOLD with cnt=LOAD_STALLS-1.
- HOLD:
  - Stall asserted regardless of hit, because EXE holds a bubble.
  - cnt decrements each cycle.
  - When cnt==1, next state is IDLE.
- Total stall per hazard is exactly LOAD_STALLS cycles.
- stall = (IDLE && hit) || HOLD. While stall is active: PCWrite=0, IFID_Write=0, IDEXE_Bubble=1.
- Flush: IFID_Flush = BranchTaken && !stall && !ExtStall. A stall has priority, so the branch re-resolves after its operands are ready.
- ExtStall=1 overrides everything:
  - PCWrite=0, IFID_Write=0, IDEXE_Bubble=0, IFID_Flush=0.
  - FSM and cnt are frozen.
  - A hit arriving during ExtStall is evaluated once ExtStall drops.
- No hazard and no ExtStall: PCWrite=1, IFID_Write=1, Bubble=0.
- O_HDU_Stalling = (state==HOLD), registered.
- Reset values:
  - state=IDLE, cnt=0, StallCycles=0, Stalling=0.
  - While RESET is high, outputs are forced to PCWrite=1, IFID_Write=1, Bubble=0, Flush=0.
- RESET asserted mid-HOLD returns to IDLE immediately, and the stall is abandoned.
- Register 0 is never a hazard.
- Back-to-back loads: a new hit is evaluated only in IDLE.

Optional Feature:
- Macro HDU_PERF_COUNT_EN.
- Defined: O_HDU_StallCycles increments by 1 on every clock where stall=1 and ExtStall=0. It saturates at 16'hFFFF and clears only on RESET.
- Undefined: O_HDU_StallCycles is tied to 16'h0000 and no counter flops are synthesized.

Decomposition:
- Shared package mips_hazard_pkg holds:
  - state encodings HDU_IDLE=1'b0, HDU_HOLD=1'b1;
  - REG_ZERO=5'd0;
  - STALL_CNT_MAX=16'hFFFF.
- One natural sub-module: hdu_hazard_compare, the combinational hit term. It is reusable by a future branch-operand hazard check.

Test Plan:
- LOAD_STALLS=1, EXE lw $5, ID add rs=$5 -> cycle 0: PCWrite=0, IFID_Write=0, Bubble=1; cycle 1 (load in MEM): all released.
- LOAD_STALLS=3, same hazard -> exactly 3 stall cycles; Stalling=1 on cycles 1–2; PCWrite returns to 1 on cycle 3.
- EXE lw $0 with ID rs=$0, or ID rt=$7 with UsesRT=0 and EXE_RT=$7 -> no stall.
- BranchTaken=1 together with hit -> Flush=0 while stalled; Flush=1 on the first non-stalled cycle that still has BranchTaken=1.
- LOAD_STALLS=3: ExtStall pulsed mid-HOLD for 2 cycles, then RESET mid-HOLD:
  - ExtStall extends the stall by 2 cycles with Bubble=0 during the freeze.
  - RESET gives PCWrite=1 and state=IDLE asynchronously.
- With HDU_PERF_COUNT_EN defined: 5 hazards at LOAD_STALLS=2 -> StallCycles=10. Preload to 16'hFFFE via force, then 3 stalls -> saturates at 16'hFFFF.
